alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arb_pkg.sv | 11 +
 rtl/alu_arbiter_alu.sv | 21 ++
 rtl/alu_arbiter.sv | 62 ++++++
 tb/tb_alu_arbiter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: command encodings and requester-id type shared by the arbiter and its ALU
package alu_arb_pkg;
  localparam logic [3:0] CMD_AND  = 4'd0;
  localparam logic [3:0] CMD_OR   = 4'd1;
  localparam logic [3:0] CMD_ADD  = 4'd2;
  localparam logic [3:0] CMD_SUB  = 4'd3;
  localparam logic [3:0] CMD_XOR  = 4'd4;
  localparam logic [3:0] CMD_PASS = 4'd5;
  localparam logic [3:0] CMD_SLTU = 4'd6;
  typedef logic req_id_t;
endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: combinational 32-bit ALU; status rides along but never alters the result
module alu_arbiter_alu
  import alu_arb_pkg::*;
(
  input  logic [31:0] val1,
  input  logic [31:0] val2,
  input  logic [3:0]  cmd,
  input  logic [3:0]  status,
  output logic [31:0] result
);
  logic unused_status;
  assign unused_status = ^status;
  always_comb
    result = cmd == CMD_AND  ? val1 & val2 :
             cmd == CMD_OR   ? val1 | val2 :
             cmd == CMD_ADD  ? val1 + val2 :
             cmd == CMD_SUB  ? val1 - val2 :
             cmd == CMD_XOR  ? val1 ^ val2 :
             cmd == CMD_PASS ? val2 :
             cmd == CMD_SLTU ? {31'd0, val1 < val2} : '0;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter in front of a shared ALU with a one-entry result register
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_val1,
  input  logic [31:0] req0_val2,
  input  logic [31:0] req1_val1,
  input  logic [31:0] req1_val2,
  input  logic [3:0]  req0_cmd,
  input  logic [3:0]  req1_cmd,
  input  logic [3:0]  req0_status,
  input  logic [3:0]  req1_status,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_id
);
  req_id_t     last_grant, gnt;
  logic        can_accept, hs;
  logic [31:0] alu_val1, alu_val2, alu_res;
  logic [3:0]  alu_cmd, alu_status;
  always_comb begin
    can_accept = !res_valid || res_ready;
    gnt        = (req0_valid && req1_valid) ? (FAIR ? !last_grant : 1'b0) : req1_valid;
    req0_ready = rst_n && can_accept && req0_valid && !gnt;
    req1_ready = rst_n && can_accept && req1_valid && gnt;
    hs         = req0_ready || req1_ready;
    alu_val1   = gnt ? req1_val1 : req0_val1;
    alu_val2   = gnt ? req1_val2 : req0_val2;
    alu_cmd    = gnt ? req1_cmd : req0_cmd;
    alu_status = gnt ? req1_status : req0_status;
  end
  alu_arbiter_alu u_alu (
    .val1   (alu_val1),
    .val2   (alu_val2),
    .cmd    (alu_cmd),
    .status (alu_status),
    .result (alu_res)
  );
  // last_grant starts at 1 so requester 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (hs) begin
      res_valid  <= 1'b1;
      res_data   <= alu_res;
      res_id     <= gnt;
      last_grant <= gnt;
    end else if (res_ready)
      res_valid <= 1'b0;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: fair and fixed-priority arbiters run side by side against a behavioural model
module tb_alu_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0, res_ready = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [3:0]  c0 = '0, c1 = '0, s0 = '0, s1 = '0;
  logic        rdy0 [2], rdy1 [2], rv [2], rid [2];
  logic [31:0] rd [2];
  int          n_vec = 0, n_err = 0;
  logic        m_v [2], m_id [2], m_lg [2];
  logic [31:0] m_d [2];
  always #5 clk = ~clk;
  alu_arbiter #(.FAIR(1'b1)) dut_fair (
    .clk(clk), .rst_n(rst_n), .req0_valid(v0), .req1_valid(v1),
    .req0_ready(rdy0[0]), .req1_ready(rdy1[0]),
    .req0_val1(a0), .req0_val2(b0), .req1_val1(a1), .req1_val2(b1),
    .req0_cmd(c0), .req1_cmd(c1), .req0_status(s0), .req1_status(s1),
    .res_valid(rv[0]), .res_ready(res_ready), .res_data(rd[0]), .res_id(rid[0])
  );
  alu_arbiter #(.FAIR(1'b0)) dut_fixed (
    .clk(clk), .rst_n(rst_n), .req0_valid(v0), .req1_valid(v1),
    .req0_ready(rdy0[1]), .req1_ready(rdy1[1]),
    .req0_val1(a0), .req0_val2(b0), .req1_val1(a1), .req1_val2(b1),
    .req0_cmd(c0), .req1_cmd(c1), .req0_status(s0), .req1_status(s1),
    .res_valid(rv[1]), .res_ready(res_ready), .res_data(rd[1]), .res_id(rid[1])
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  function automatic logic [31:0] alu_ref(input logic [3:0] cmd, input logic [31:0] x, input logic [31:0] y);
    case (cmd)
      4'd0: return x & y;
      4'd1: return x | y;
      4'd2: return x + y;
      4'd3: return x - y;
      4'd4: return x ^ y;
      4'd5: return y;
      4'd6: return (x < y) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction
  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction
  // model: index 0 is the round-robin instance, index 1 the fixed-priority one
  always @(negedge clk)
    for (int k = 0; k < 2; k++)
      if (!rst_n) begin
        chk($sformatf("rst_valid%0d", k), 32'(rv[k]), 32'd0);
        chk($sformatf("rst_data%0d", k), rd[k], 32'd0);
        chk($sformatf("rst_id%0d", k), 32'(rid[k]), 32'd0);
        chk($sformatf("rst_ready%0d", k), {30'd0, rdy1[k], rdy0[k]}, 32'd0);
        m_v[k] = 1'b0; m_d[k] = '0; m_id[k] = 1'b0; m_lg[k] = 1'b1;
      end else begin
        logic winner, space, e0, e1;
        chk($sformatf("res_valid%0d", k), 32'(rv[k]), 32'(m_v[k]));
        if (m_v[k]) begin
          chk($sformatf("res_data%0d", k), rd[k], m_d[k]);
          chk($sformatf("res_id%0d", k), 32'(rid[k]), 32'(m_id[k]));
        end
        if (v0 && v1) winner = (k == 0) ? (m_lg[k] == 1'b0) : 1'b0;
        else winner = v1;
        space = !m_v[k] || res_ready;
        e0 = space && v0 && winner == 1'b0;
        e1 = space && v1 && winner == 1'b1;
        chk($sformatf("req0_ready%0d", k), 32'(rdy0[k]), 32'(e0));
        chk($sformatf("req1_ready%0d", k), 32'(rdy1[k]), 32'(e1));
        if (e0 || e1) begin
          m_v[k] = 1'b1;
          m_d[k] = e1 ? alu_ref(c1, a1, b1) : alu_ref(c0, a0, b0);
          m_id[k] = e1;
          m_lg[k] = e1;
        end else if (res_ready) m_v[k] = 1'b0;
      end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) step();
    rst_n = 1'b1;
    v0 = 1; v1 = 1; res_ready = 1;
    a0 = 32'd10; b0 = 32'd1; c0 = 4'd2; a1 = 32'd20; b1 = 32'd2; c1 = 4'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rr_grant0_%0d", i), 32'(rdy0[0]), 32'(i % 2 == 0));
      chk($sformatf("rr_grant1_%0d", i), 32'(rdy1[0]), 32'(i % 2 == 1));
      chk($sformatf("fix_grant0_%0d", i), {30'd0, rdy1[1], rdy0[1]}, 32'd1);
      step();
      chk($sformatf("rr_res_%0d", i), rd[0], (i % 2 == 0) ? 32'd11 : 32'd22);
    end
    v0 = 0; v1 = 0;
    step();
    v0 = 1; a0 = 32'd5; b0 = 32'd3; c0 = 4'd2;
    step();
    chk("add_valid", 32'(rv[0]), 32'd1);
    chk("add_data", rd[0], 32'd8);
    chk("add_id", 32'(rid[0]), 32'd0);
    v0 = 0; v1 = 1; a1 = 32'd0; b1 = 32'd1; c1 = 4'd3; res_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_data", rd[0], 32'd8);
      chk("bp_valid", 32'(rv[0]), 32'd1);
      chk("bp_ready", {30'd0, rdy1[0], rdy0[0]}, 32'd0);
      step();
    end
    res_ready = 1;
    step();
    chk("sub_data", rd[0], 32'hFFFF_FFFF);
    chk("sub_id", 32'(rid[0]), 32'd1);
    v1 = 0; v0 = 1; a0 = 32'h8000_0000; b0 = 32'd1; c0 = 4'd6;
    step();
    chk("sltu_data", rd[0], 32'd0);
    a0 = 32'h0000_00F0; b0 = 32'h0000_000F; c0 = 4'd1;
    step();
    chk("or_data", rd[0], 32'h0000_00FF);
    a0 = 32'd7; b0 = 32'd7; c0 = 4'd9;
    step();
    chk("cmd9_data", rd[0], 32'd0);
    repeat (400) begin
      v0 = $urandom_range(0, 3) != 0; v1 = $urandom_range(0, 3) != 0;
      a0 = rnd32(); b0 = rnd32(); a1 = rnd32(); b1 = rnd32();
      c0 = 4'($urandom_range(0, 15)); c1 = 4'($urandom_range(0, 15));
      s0 = 4'($urandom); s1 = 4'($urandom);
      res_ready = $urandom_range(0, 9) < 7;
      step();
    end
    v0 = 1; v1 = 0; res_ready = 1; a0 = 32'd1; b0 = 32'd1; c0 = 4'd2;
    step();
    v0 = 0; res_ready = 0;
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("async_valid0", 32'(rv[0]), 32'd0);
    chk("async_valid1", 32'(rv[1]), 32'd0);
    chk("async_ready", {30'd0, rdy1[0], rdy0[0]}, 32'd0);
    step();
    rst_n = 1; res_ready = 1;
    @(negedge clk);
    chk("post_rst_valid", 32'(rv[0]), 32'd0);
    step();
    v0 = 1; v1 = 1;
    @(negedge clk);
    chk("post_rst_tie0", 32'(rdy0[0]), 32'd1);
    chk("post_rst_tie1", 32'(rdy1[0]), 32'd0);
    step();
    v0 = 0; v1 = 0;
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
